// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared UART state encodings and default frame geometry
package uart_rx_pkg;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_NB_DATA = 8;
  localparam int DEF_SB_TICK = 16;
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: line-side inputs and byte-side outputs of the receiver (parity_err with UART_RX_PARITY_EN)
interface uart_rx_if #(parameter int NB_DATA = 8);
  logic tick;
  logic rx;
  logic [NB_DATA-1:0] data;
  logic rx_done;
  logic frame_err;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  modport master (output tick, rx, input data, rx_done, frame_err, parity_err);
  modport slave (input tick, rx, output data, rx_done, frame_err, parity_err);
`else
  modport master (output tick, rx, input data, rx_done, frame_err);
  modport slave (input tick, rx, output data, rx_done, frame_err);
`endif
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous input with selectable reset value
module sync_2ff #(parameter logic RST_VAL = 1'b1) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic meta;
  // shift the async input through two flops before anyone uses it
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) {o_q, meta} <= {RST_VAL, RST_VAL};
    else {o_q, meta} <= {meta, i_d};
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, LSB first, optional even parity via UART_RX_PARITY_EN
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int NB_DATA = DEF_NB_DATA,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input logic i_clk,
  input logic i_reset_n,
  uart_rx_if.slave bus
);
  localparam int SW = ($clog2(SB_TICK) > $clog2(OVERSAMPLE)) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int NW = $clog2(NB_DATA);
  state_t state, state_n;
  logic rx_s;
  logic [SW-1:0] s_cnt, s_cnt_n;
  logic [NW-1:0] n_cnt, n_cnt_n;
  logic [NB_DATA-1:0] shift, shift_n, data_q, data_n;
  logic done_q, done_n, ferr_q, ferr_n;
  logic mid, bit_end, stop_end, last;
`ifdef UART_RX_PARITY_EN
  logic par, par_n, perr_q, perr_n;
  assign bus.parity_err = perr_q;
`endif
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.i_clk(i_clk), .i_reset_n(i_reset_n), .i_d(bus.rx), .o_q(rx_s));
  assign mid = s_cnt == SW'(OVERSAMPLE / 2 - 1);
  assign bit_end = s_cnt == SW'(OVERSAMPLE - 1);
  assign stop_end = s_cnt == SW'(SB_TICK - 1);
  assign last = n_cnt == NW'(NB_DATA - 1);
  assign bus.data = data_q;
  assign bus.rx_done = done_q;
  assign bus.frame_err = ferr_q;
  // state and datapath registers; reset discards any partial frame
  always_ff @(posedge i_clk or negedge i_reset_n)
    if (!i_reset_n) begin
      state <= ST_IDLE;
      s_cnt <= '0;
      n_cnt <= '0;
      shift <= '0;
      data_q <= '0;
      done_q <= 1'b0;
      ferr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      s_cnt <= s_cnt_n;
      n_cnt <= n_cnt_n;
      shift <= shift_n;
      data_q <= data_n;
      done_q <= done_n;
      ferr_q <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par <= par_n;
      perr_q <= perr_n;
`endif
    end
  // frame sequencing: start is confirmed at mid-bit, everything else moves on bit/stop boundaries
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: state_n = rx_s ? ST_IDLE : ST_START;
      ST_START: if (bus.tick && mid) state_n = rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA: if (bus.tick && bit_end && last) state_n = ST_PARITY;
      ST_PARITY: if (bus.tick && bit_end) state_n = ST_STOP;
`else
      ST_DATA: if (bus.tick && bit_end && last) state_n = ST_STOP;
`endif
      ST_STOP: if (bus.tick && stop_end) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  // counters, shifter and output updates; nothing moves without a tick except idle start detection
  always_comb begin
    s_cnt_n = s_cnt;
    n_cnt_n = n_cnt;
    shift_n = shift;
    data_n = data_q;
    done_n = 1'b0;
    ferr_n = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_n = par;
    perr_n = perr_q;
`endif
    case (state)
      ST_IDLE: s_cnt_n = '0;
      ST_START: if (bus.tick) begin
        s_cnt_n = mid ? '0 : s_cnt + 1'b1;
        n_cnt_n = '0;
      end
      ST_DATA: if (bus.tick) begin
        s_cnt_n = bit_end ? '0 : s_cnt + 1'b1;
        if (bit_end) begin
          shift_n = {rx_s, shift[NB_DATA-1:1]};
          n_cnt_n = last ? n_cnt : n_cnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: if (bus.tick) begin
        s_cnt_n = bit_end ? '0 : s_cnt + 1'b1;
        if (bit_end) par_n = rx_s;
      end
`endif
      ST_STOP: if (bus.tick) begin
        s_cnt_n = stop_end ? '0 : s_cnt + 1'b1;
        if (stop_end) begin
          data_n = shift;
          ferr_n = ~rx_s;
          done_n = 1'b1;
`ifdef UART_RX_PARITY_EN
          perr_n = ^{shift, par};
`endif
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frame vectors plus glitch, stop-error and mid-frame reset sequences
module tb_uart_rx;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  logic [7:0] q_data[$];
  logic q_ferr[$];
  logic q_perr[$];
  typedef struct {
    logic [7:0] d;
    logic stop;
    int idle;
    logic ferr;
  } vec_t;
  vec_t vecs[5];
  uart_rx_if bus ();
  uart_rx dut (.i_clk(clk), .i_reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    int c = 0;
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      bus.tick = (c == 3);
      c = (c + 1) % 4;
    end
  end
  always @(negedge clk)
    if (bus.rx_done) begin
      q_data.push_back(bus.data);
      q_ferr.push_back(bus.frame_err);
`ifdef UART_RX_PARITY_EN
      q_perr.push_back(bus.parity_err);
`else
      q_perr.push_back(1'b0);
`endif
    end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (64) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pbad);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ pbad);
`endif
    drive_bit(stop);
  endtask
  task automatic expect_frame(input string name, input logic [7:0] d, input logic ferr, input logic perr);
    check({name, " pulses"}, q_data.size(), 1);
    if (q_data.size() > 0) begin
      check({name, " data"}, q_data[0], d);
      check({name, " frame_err"}, q_ferr[0], ferr);
`ifdef UART_RX_PARITY_EN
      check({name, " parity_err"}, q_perr[0], perr);
`endif
    end
    q_data.delete();
    q_ferr.delete();
    q_perr.delete();
  endtask
  initial begin
    vecs[0] = '{8'h55, 1'b1, 0, 1'b0};
    vecs[1] = '{8'hA3, 1'b1, 0, 1'b0};
    vecs[2] = '{8'h0F, 1'b1, 0, 1'b0};
    vecs[3] = '{8'hC6, 1'b0, 128, 1'b1};
    vecs[4] = '{8'h5A, 1'b1, 0, 1'b0};
    rst_n = 1'b0;
    bus.rx = 1'b1;
    @(negedge clk);
    check("reset data", bus.data, 0);
    check("reset done", bus.rx_done, 0);
    check("reset frame_err", bus.frame_err, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (64) @(negedge clk);
    check("idle no pulse", q_data.size(), 0);
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, 1'b0);
      expect_frame($sformatf("vec%0d", i), vecs[i].d, vecs[i].ferr, 1'b0);
      if (vecs[i].idle > 0) begin
        bus.rx = 1'b1;
        repeat (vecs[i].idle) @(negedge clk);
        check($sformatf("vec%0d idle pulses", i), q_data.size(), 0);
      end
    end
    bus.rx = 1'b0;
    repeat (16) @(negedge clk);
    bus.rx = 1'b1;
    repeat (128) @(negedge clk);
    check("glitch no pulse", q_data.size(), 0);
    check("glitch data held", bus.data, 8'h5A);
    send_frame(8'h81, 1'b1, 1'b0);
    expect_frame("after glitch", 8'h81, 1'b0, 1'b0);
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'b1);
    bus.rx = 1'b1;
    repeat (32) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset data", bus.data, 0);
    check("midreset done", bus.rx_done, 0);
    check("midreset frame_err", bus.frame_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (128) @(negedge clk);
    check("midreset no pulse", q_data.size(), 0);
    send_frame(8'h3C, 1'b1, 1'b0);
    expect_frame("after reset", 8'h3C, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    expect_frame("parity bad", 8'h07, 1'b0, 1'b1);
    send_frame(8'h07, 1'b1, 1'b0);
    expect_frame("parity good", 8'h07, 1'b0, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
